// File: rtl/clk_div_ctrl.sv
// Configuration front-end for the integer clock divider. Accepts ratio
// requests over valid/ready, rejects out-of-range ratios, and applies a
// legal new ratio with a hold-reset / load / release / re-enable sequence
// so the divider never sees a ratio change while it is running.
module clk_div_ctrl #(
  parameter int RATIO_WIDTH    = 4,
  parameter int MAX_RATIO      = 15,
  parameter int DEFAULT_RATIO  = 1,
  parameter int QUIESCE_CYCLES = 4
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_cfg_valid,
  input  logic [RATIO_WIDTH-1:0] i_cfg_ratio,
  output logic                   o_cfg_ready,
  output logic                   o_cfg_done,
  output logic                   o_cfg_err,
  output logic                   o_busy,
  output logic [RATIO_WIDTH-1:0] o_div_ratio,
  output logic                   o_clk_en,
  output logic                   o_div_rst_n
);

  localparam int CW = $clog2(QUIESCE_CYCLES + 1);

  // ENABLE is the completion cycle; it accepts requests exactly like IDLE
  // so a new request can be taken in the same cycle done pulses.
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RELEASE, S_ENABLE} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   hs, legal, same, do_switch;

  logic [RATIO_WIDTH-1:0] ratio_d;
  logic                   clk_en_d, rst_n_d, ready_d, busy_d, done_d, err_d;

  assign hs        = i_cfg_valid && o_cfg_ready;
  assign legal     = (int'(i_cfg_ratio) <= MAX_RATIO);
  assign same      = (i_cfg_ratio == o_div_ratio);
  assign do_switch = hs && legal && !same;

  // State and hold-counter registers; reset aborts any sequence in flight
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and hold counter: counter loads 1 entering HOLD, exits at QUIESCE_CYCLES
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE, S_ENABLE: begin
        state_d = do_switch ? S_HOLD : S_IDLE;
        if (do_switch) cnt_d = CW'(1);
      end
      S_HOLD: begin
        if (cnt_q == CW'(QUIESCE_CYCLES)) state_d = S_RELEASE;
        else                              cnt_d   = cnt_q + CW'(1);
      end
      S_RELEASE: state_d = S_ENABLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next output values, derived from the state being entered so every output is a flop
  always_comb begin
    ratio_d  = do_switch ? i_cfg_ratio : o_div_ratio;
    ready_d  = (state_d == S_IDLE) || (state_d == S_ENABLE);
    busy_d   = (state_d == S_HOLD) || (state_d == S_RELEASE);
    rst_n_d  = (state_d != S_HOLD);
    clk_en_d = ready_d && (ratio_d >= RATIO_WIDTH'(2));
    done_d   = (state_d == S_ENABLE) || (hs && legal && same);
    err_d    = hs && !legal;
  end

  // Output registers with reset values; divider held in reset during i_rst
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      o_div_ratio <= RATIO_WIDTH'(DEFAULT_RATIO);
      o_clk_en    <= 1'b0;
      o_div_rst_n <= 1'b0;
      o_cfg_ready <= 1'b0;
      o_busy      <= 1'b0;
      o_cfg_done  <= 1'b0;
      o_cfg_err   <= 1'b0;
    end else begin
      o_div_ratio <= ratio_d;
      o_clk_en    <= clk_en_d;
      o_div_rst_n <= rst_n_d;
      o_cfg_ready <= ready_d;
      o_busy      <= busy_d;
      o_cfg_done  <= done_d;
      o_cfg_err   <= err_d;
    end
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Configuration front-end that sits directly upstream of the integer clock divider and drives its ratio, clock-enable and reset inputs.
- Accepts new divide ratios from the register file over a valid/ready handshake and range-checks them.
- Applies each accepted ratio with a glitch-safe switch sequence: hold divider in reset, load ratio, release, then re-enable.
- Ratios 0 and 1 leave the divider disabled, so the reference clock passes through.

Parameters:
- RATIO_WIDTH, 4: width of the ratio bus; matches the divider's ratio input.
- MAX_RATIO, 15: largest legal ratio; requests above it are rejected.
- DEFAULT_RATIO, 1: ratio loaded at reset.
- QUIESCE_CYCLES, 4: cycles o_div_rst_n is held low per switch; legal range 1..15.

Ports:
- i_ref_clk  in  1  reference clock, the single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_cfg_valid  in  1  config request valid.
- i_cfg_ratio  in  RATIO_WIDTH  requested divide ratio.
- o_cfg_ready  out  1  controller can accept a request.
- o_cfg_done  out  1  one-cycle pulse: request completed or was a no-op.
- o_cfg_err  out  1  one-cycle pulse: request rejected, ratio > MAX_RATIO.
- o_busy  out  1  switch sequence in progress.
- o_div_ratio  out  RATIO_WIDTH  ratio driven to the divider.
- o_clk_en  out  1  divider enable.
- o_div_rst_n  out  1  active-low divider reset, registered.

Behaviour:
- All outputs are registered. Handshake occurs on a cycle where i_cfg_valid && o_cfg_ready; call it cycle T.
- Reset values (while i_rst=1):
  - o_div_ratio=DEFAULT_RATIO, o_clk_en=0, o_div_rst_n=0, o_cfg_ready=0, o_busy=0, o_cfg_done=0, o_cfg_err=0.
  - First cycle after reset deasserts: o_div_rst_n=1, o_cfg_ready=1, o_clk_en=(DEFAULT_RATIO>=2).
- FSM states:
  - IDLE: o_cfg_ready=1.
  - HOLD: o_div_rst_n=0, o_clk_en=0, counter runs.
  - RELEASE: o_div_rst_n=1, o_clk_en=0.
  - ENABLE: completion cycle.
- Request at T is rejected when i_cfg_ratio > MAX_RATIO:
  - o_cfg_err=1 at T+1 only.
  - No output changes and FSM stays IDLE.
- Request at T is a no-op when the ratio is legal and equals o_div_ratio:
  - o_cfg_done=1 at T+1; FSM stays IDLE and o_cfg_ready stays 1.
- Request at T is a switch when the ratio is legal and differs from o_div_ratio:
  - T+1 to T+QUIESCE_CYCLES (HOLD): o_div_ratio=new, o_div_rst_n=0, o_clk_en=0, o_cfg_ready=0, o_busy=1.
  - T+QUIESCE_CYCLES+1 (RELEASE): o_div_rst_n=1, o_clk_en=0, o_busy=1.
  - T+QUIESCE_CYCLES+2 (IDLE): o_clk_en=(new>=2), o_cfg_done=1 for one cycle, o_busy=0, o_cfg_ready=1.
- o_div_ratio changes only on the cycle where o_div_rst_n goes low. It is never changed while o_clk_en=1.
- HOLD counter:
  - Width is ceil(log2(QUIESCE_CYCLES+1)).
  - Loads 1 on entry to HOLD and increments each cycle.
  - Leaves HOLD on the cycle its value equals QUIESCE_CYCLES.
  - Never wraps.
- i_cfg_valid while o_cfg_ready=0 is ignored. The source must hold the request; it is accepted on the first cycle ready returns.
- A new request may be accepted in the same cycle o_cfg_done pulses (back-to-back).
- o_cfg_done and o_cfg_err are never high together.
- Reset mid-sequence (i_rst=1 in any state) aborts immediately to the reset values. The pending ratio is discarded and no done pulse is issued.
- Ratios 0 and 1 are legal. They end with o_clk_en=0 (bypass) but still run the full switch sequence when they differ from the current ratio.

Test Plan:
1. Release reset with DEFAULT_RATIO=1 -> o_div_rst_n=1, o_cfg_ready=1, o_clk_en=0, o_div_ratio=1 on first cycle after reset.
2. Request ratio 6 at T -> o_div_rst_n=0 at T+1..T+4, o_div_ratio=6 from T+1, o_div_rst_n=1 at T+5, o_clk_en=1 and o_cfg_done=1 at T+6, o_cfg_ready=1 at T+6.
3. With ratio 6 active, request 6 -> o_cfg_done at T+1, o_div_rst_n never low, o_clk_en stays 1. Then request 1 -> full sequence, ending o_clk_en=0, o_div_ratio=1.
4. With MAX_RATIO=12, request 13 -> o_cfg_err=1 at T+1 only, o_div_ratio/o_clk_en unchanged. Then request 12 -> accepted normally.
5. Hold i_cfg_valid with ratio 3 continuously from T+2 of a ratio-5 switch -> not accepted until T+6. Second switch begins at T+7 (o_div_rst_n=0), ending with o_div_ratio=3, o_clk_en=1.
6. Assert i_rst at T+3 of a switch to ratio 9 -> next cycle o_div_ratio=DEFAULT_RATIO, o_div_rst_n=0, o_busy=0. No o_cfg_done at any later point.
